// File: rtl/scale_pkg.sv
// Shared types and helpers for the scaler line-fetch path: FSM states and
// the frame-memory address packing shared with the vin_ctrl writer.
package scale_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

    localparam int PIX_SHIFT = 2;

    // Frame memory word address: line in the upper half, byte offset of the
    // pixel in the lower half (wraps at 16 bits, matching the writer side).
    function automatic logic [31:0] mk_addr(input logic [15:0] y, input logic [15:0] x);
        logic [15:0] xs;
        xs = x << PIX_SHIFT;
        return {y, xs};
    endfunction

endpackage

// File: rtl/scale_fetch_ctr.sv
// Two-line (sel, x) position counter: walks x = 0..xres-1 for sel=0, then
// again for sel=1. Used both for issuing reads and for tracking returns.
module scale_fetch_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        adv,
    input  logic [15:0] xres,
    output logic        sel,
    output logic [15:0] x,
    output logic        last
);

    logic line_end;

    assign line_end = (x == xres - 16'd1);
    assign last     = sel && line_end;

    // NOTE: reset is synchronous here, so rst_n is only looked at on a clk edge
    // and never appears in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            // NOTE: state registers are always written with <= so that every
            // flop in the design samples the pre-edge values of its inputs.
            sel <= 1'b0;
            x   <= '0;
        end else if (adv) begin
            if (line_end) begin
                sel <= 1'b1;
                x   <= '0;
            end else begin
                x <= x + 16'd1;
            end
        end
    end

endmodule

// File: rtl/scale_line_fetch.sv
// Fetches a pair of adjacent source lines from frame memory through a
// pipelined read port and streams them into the bilinear scaler's line RAM.
module scale_line_fetch
    import scale_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 32,
    parameter int MAX_OUT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_sync_n,
    input  logic [15:0]   vin_xres,
    input  logic [15:0]   vin_yres,
    input  logic          fetch_en,
    input  logic [15:0]   fetch_line,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_gnt,
    input  logic          rd_dvalid,
    input  logic [DW-1:0] rd_data,
    output logic          wr_ram_en,
    output logic [DW-1:0] ram_dat,
    output logic [15:0]   ram_x,
    output logic          ram_sel,
    output logic          fetch_done,
    output logic          busy
);

    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam logic [OW-1:0] MAX_Q = OW'(MAX_OUT);

    fetch_state_t state;

    logic [15:0]   xres_q;
    logic [15:0]   line_a;
    logic [15:0]   line_b;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] out_nxt;

    logic          accept;
    logic          fire;
    logic          ret;
    logic          ret_adv;
    logic          wr_take;

    logic          iss_sel;
    logic [15:0]   iss_x;
    logic          iss_last;
    logic          ret_sel;
    logic [15:0]   ret_x;
    logic          ret_last;

    logic [15:0]   ym1;
    logic [15:0]   line_a_c;
    logic [16:0]   line_p1;
    logic [15:0]   line_b_c;

    // Clamp the requested pair to the frame so the bottom line is replicated;
    // the +1 is done in 17 bits so line 0xFFFF does not wrap to line 0.
    always_comb begin
        ym1      = vin_yres - 16'd1;
        line_a_c = (fetch_line > ym1) ? ym1 : fetch_line;
        line_p1  = {1'b0, fetch_line} + 17'd1;
        line_b_c = (line_p1 > {1'b0, ym1}) ? ym1 : line_p1[15:0];
    end

    assign accept  = (state == IDLE) && fetch_en && frame_sync_n;
    assign fire    = rd_req && rd_gnt;
    assign ret     = rd_dvalid && (outstanding != '0);
    assign ret_adv = rd_dvalid && ((state == REQ) || (state == WAIT));
    assign wr_take = ret_adv && frame_sync_n;
    assign out_nxt = outstanding + OW'(fire) - OW'(ret);

    // The address follows the issue counter directly, so it only moves on a
    // grant and stays put while a request is stalled.
    assign rd_addr = AW'(mk_addr(iss_sel ? line_b : line_a, iss_x));

    scale_fetch_ctr u_issue_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .adv   (fire),
        .xres  (xres_q),
        .sel   (iss_sel),
        .x     (iss_x),
        .last  (iss_last)
    );

    scale_fetch_ctr u_return_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .adv   (ret_adv),
        .xres  (xres_q),
        .sel   (ret_sel),
        .x     (ret_x),
        .last  (ret_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            outstanding <= out_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            xres_q     <= '0;
            line_a     <= '0;
            line_b     <= '0;
            rd_req     <= 1'b0;
            fetch_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        xres_q <= vin_xres;
                        line_a <= line_a_c;
                        line_b <= line_b_c;
                        busy   <= 1'b1;
                        if (vin_xres == '0 || vin_yres == '0) begin
                            state <= DONE;
                        end else begin
                            state  <= REQ;
                            rd_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (!frame_sync_n) begin
                        rd_req <= 1'b0;
                        state  <= DRAIN;
                    end else if (fire && iss_last) begin
                        rd_req <= 1'b0;
                        state  <= WAIT;
                    end else begin
                        // A grant and a return in the same cycle cancel out.
                        rd_req <= (out_nxt < MAX_Q);
                    end
                end
                WAIT: begin
                    if (!frame_sync_n) begin
                        state <= DRAIN;
                    end else if (ret_adv && ret_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    fetch_done <= 1'b1;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                DRAIN: begin
                    if (out_nxt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rd_req <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // Single register stage toward the line RAM; beats seen during an abort
    // are dropped here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ram_en <= 1'b0;
            ram_dat   <= '0;
            ram_x     <= '0;
            ram_sel   <= 1'b0;
        end else begin
            wr_ram_en <= wr_take;
            if (wr_take) begin
                ram_dat <= rd_data;
                ram_x   <= ret_x;
                ram_sel <= ret_sel;
            end
        end
    end

endmodule
